// File: rtl/impl_monitor_pkg.sv
// -----------------------------------------------------------------------------
// impl_monitor_pkg
// Shared definitions for the implication monitor:
//   mon_state_e  - monitor verdict state (CLEAN until the first violation)
//   DELAY_MIN/MAX - legal range of the antecedent-to-consequent distance
// -----------------------------------------------------------------------------
package impl_monitor_pkg;

    typedef enum logic {
        CLEAN  = 1'b0,
        FAILED = 1'b1
    } mon_state_e;

    localparam int DELAY_MIN = 1;
    localparam int DELAY_MAX = 16;

endpackage : impl_monitor_pkg

// File: rtl/obligation_pipe.sv
// -----------------------------------------------------------------------------
// obligation_pipe
// Shift register of outstanding obligations. A qualified trigger enters at
// bit 0 and reaches the MSB exactly DELAY cycles later (the check cycle).
//
// Ports:
//   CLK      in   sole clock, rising edge
//   RESET    in   synchronous active-high reset
//   clear    in   synchronous soft clear (drops every obligation)
//   trigger  in   qualified antecedent (enable & antecedent)
//   due      out  an obligation is being checked this cycle
//   pending  out  at least one obligation is outstanding
// -----------------------------------------------------------------------------
module obligation_pipe #(
    parameter int DELAY = 1
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic trigger,
    output logic due,
    output logic pending
);

    logic [DELAY-1:0] pipe;

    // NOTE: sequential state uses non-blocking assignments so every bit of the
    // shift register samples the value its neighbour held before the edge.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            // NOTE: this register holds live obligations, so it must be
            // cleared; a stale bit would report a violation nobody triggered.
            pipe <= '0;
        end else begin
            pipe[0] <= trigger;
            for (int i = 1; i < DELAY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign due     = pipe[DELAY-1];
    assign pending = |pipe;

endmodule : obligation_pipe

// File: rtl/implication_monitor.sv
// -----------------------------------------------------------------------------
// implication_monitor
// Run-time checker for  antecedent |-> ##DELAY consequent.
// Overlapping obligations are checked independently; violations are flagged
// (registered one-cycle pulse), counted (saturating) and the first one is
// timestamped with a free-running cycle counter.
//
// Parameters:
//   DELAY  cycles between trigger and check (1..16)
//   CNT_W  width of the failure counter
//   TS_W   width of the cycle counter / first-failure timestamp
//
// Ports:
//   CLK            in   sole clock, rising edge
//   RESET          in   synchronous active-high reset
//   enable         in   qualifies new obligations only
//   antecedent     in   property trigger
//   consequent     in   value checked DELAY cycles after a qualified trigger
//   clear          in   synchronous soft clear of all monitor state
//   fail           out  one-cycle pulse per violated obligation
//   fail_sticky    out  high from the first violation until RESET/clear
//   fail_count     out  saturating violation count
//   first_fail_ts  out  cycle counter value at the check of the first violation
//   pending        out  at least one obligation outstanding
//
// Build option: define IMPL_MONITOR_SVA_EN to add a simulation-only concurrent
// assertion of the same property and an elaboration check on DELAY.
// -----------------------------------------------------------------------------
module implication_monitor
    import impl_monitor_pkg::*;
#(
    parameter int DELAY = 1,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             enable,
    input  logic             antecedent,
    input  logic             consequent,
    input  logic             clear,
    output logic             fail,
    output logic             fail_sticky,
    output logic [CNT_W-1:0] fail_count,
    output logic [TS_W-1:0]  first_fail_ts,
    output logic             pending
);

    mon_state_e      state;
    mon_state_e      state_next;
    logic            capture_ts;
    logic            trigger;
    logic            due;
    logic            violation;
    logic [TS_W-1:0] ts;

    assign trigger   = enable & antecedent;
    assign violation = due & ~consequent;

    obligation_pipe #(
        .DELAY (DELAY)
    ) u_pipe (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (clear),
        .trigger (trigger),
        .due     (due),
        .pending (pending)
    );

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            state <= CLEAN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        capture_ts = 1'b0;
        case (state)
            CLEAN: begin
                if (violation) begin
                    state_next = FAILED;
                    capture_ts = 1'b1;
                end
            end
            FAILED:  state_next = FAILED;
            default: state_next = CLEAN;
        endcase
    end

    assign fail_sticky = (state == FAILED);

    // Clear outranks a same-cycle violation, so it is simply dropped here.
    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            ts            <= '0;
            fail          <= 1'b0;
            fail_count    <= '0;
            first_fail_ts <= '0;
        end else begin
            ts   <= ts + TS_W'(1);
            fail <= violation;
            if (violation && (fail_count != {CNT_W{1'b1}})) begin
                fail_count <= fail_count + CNT_W'(1);
            end
            if (capture_ts) begin
                first_fail_ts <= ts;
            end
        end
    end

`ifdef IMPL_MONITOR_SVA_EN
    if ((DELAY < DELAY_MIN) || (DELAY > DELAY_MAX)) begin : g_delay_range
        $error("implication_monitor: DELAY=%0d outside %0d..%0d",
               DELAY, DELAY_MIN, DELAY_MAX);
    end

    a_implication: assert property (
        @(posedge CLK) disable iff (RESET || clear)
        enable && antecedent |-> ##DELAY consequent
    );
`else
`endif

endmodule : implication_monitor

// File: tb/tb_implication_monitor.sv
// -----------------------------------------------------------------------------
// tb_implication_monitor
// Directed bench for implication_monitor. Four instances (DELAY = 1..4) share
// one set of inputs; each scenario exercises one instance. Cycle k is the k-th
// cycle after RESET is released, so the monitor's cycle counter reads k there.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_implication_monitor;

    logic CLK = 1'b0;
    logic RESET;
    logic enable;
    logic antecedent;
    logic consequent;
    logic clear;

    logic        d1_fail, d1_sticky, d1_pending;
    logic [1:0]  d1_count;
    logic [15:0] d1_ts;
    logic        d2_fail, d2_sticky, d2_pending;
    logic [7:0]  d2_count;
    logic [15:0] d2_ts;
    logic        d3_fail, d3_sticky, d3_pending;
    logic [7:0]  d3_count;
    logic [15:0] d3_ts;
    logic        d4_fail, d4_sticky, d4_pending;
    logic [7:0]  d4_count;
    logic [15:0] d4_ts;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    implication_monitor #(.DELAY(1), .CNT_W(2), .TS_W(16)) u_d1 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .antecedent(antecedent),
        .consequent(consequent), .clear(clear), .fail(d1_fail),
        .fail_sticky(d1_sticky), .fail_count(d1_count),
        .first_fail_ts(d1_ts), .pending(d1_pending)
    );

    implication_monitor #(.DELAY(2), .CNT_W(8), .TS_W(16)) u_d2 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .antecedent(antecedent),
        .consequent(consequent), .clear(clear), .fail(d2_fail),
        .fail_sticky(d2_sticky), .fail_count(d2_count),
        .first_fail_ts(d2_ts), .pending(d2_pending)
    );

    implication_monitor #(.DELAY(3), .CNT_W(8), .TS_W(16)) u_d3 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .antecedent(antecedent),
        .consequent(consequent), .clear(clear), .fail(d3_fail),
        .fail_sticky(d3_sticky), .fail_count(d3_count),
        .first_fail_ts(d3_ts), .pending(d3_pending)
    );

    implication_monitor #(.DELAY(4), .CNT_W(8), .TS_W(16)) u_d4 (
        .CLK(CLK), .RESET(RESET), .enable(enable), .antecedent(antecedent),
        .consequent(consequent), .clear(clear), .fail(d4_fail),
        .fail_sticky(d4_sticky), .fail_count(d4_count),
        .first_fail_ts(d4_ts), .pending(d4_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
    endtask

    // Two reset edges; on return we are in cycle 0 with RESET released.
    task automatic do_reset();
        RESET      = 1'b1;
        enable     = 1'b1;
        antecedent = 1'b0;
        consequent = 1'b0;
        clear      = 1'b0;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // ---- DELAY=1, consequent holds: no failure ----
        do_reset();
        check("rst_fail",    32'(d1_fail),    32'd0);
        check("rst_sticky",  32'(d1_sticky),  32'd0);
        check("rst_count",   32'(d1_count),   32'd0);
        check("rst_ts",      32'(d1_ts),      32'd0);
        check("rst_pending", 32'(d1_pending), 32'd0);
        go_to(5);  antecedent = 1'b1;
        check("d1_pass_pend5", 32'(d1_pending), 32'd0);
        go_to(6);  antecedent = 1'b0; consequent = 1'b1;
        check("d1_pass_pend6", 32'(d1_pending), 32'd1);
        go_to(7);  consequent = 1'b0;
        check("d1_pass_pend7", 32'(d1_pending), 32'd0);
        check("d1_pass_fail7", 32'(d1_fail),    32'd0);
        go_to(8);
        check("d1_pass_fail8",  32'(d1_fail),  32'd0);
        check("d1_pass_count8", 32'(d1_count), 32'd0);

        // ---- DELAY=1, consequent low: one failure ----
        do_reset();
        go_to(5);  antecedent = 1'b1;
        go_to(6);  antecedent = 1'b0; consequent = 1'b0;
        go_to(7);
        check("d1_viol_fail7",   32'(d1_fail),   32'd1);
        check("d1_viol_sticky7", 32'(d1_sticky), 32'd1);
        check("d1_viol_count7",  32'(d1_count),  32'd1);
        check("d1_viol_ts7",     32'(d1_ts),     32'd6);
        go_to(8);
        check("d1_viol_fail8",   32'(d1_fail),   32'd0);
        check("d1_viol_sticky8", 32'(d1_sticky), 32'd1);

        // ---- DELAY=2, overlapping triggers ----
        do_reset();
        go_to(10); antecedent = 1'b1;
        go_to(12); consequent = 1'b0;
        go_to(13); antecedent = 1'b0; consequent = 1'b1;
        check("d2_fail13",  32'(d2_fail),  32'd1);
        check("d2_count13", 32'(d2_count), 32'd1);
        check("d2_ts13",    32'(d2_ts),    32'd12);
        go_to(14); consequent = 1'b0;
        check("d2_fail14",  32'(d2_fail),  32'd0);
        go_to(15); consequent = 1'b1;
        check("d2_fail15",   32'(d2_fail),   32'd1);
        check("d2_count15",  32'(d2_count),  32'd2);
        check("d2_ts15",     32'(d2_ts),     32'd12);
        check("d2_sticky15", 32'(d2_sticky), 32'd1);
        go_to(16);
        check("d2_fail16",    32'(d2_fail),    32'd0);
        check("d2_pending16", 32'(d2_pending), 32'd0);

        // ---- DELAY=3, enable dropped with an obligation in flight ----
        do_reset();
        go_to(4);  antecedent = 1'b1;
        go_to(5);  enable = 1'b0;
        check("d3_pending5", 32'(d3_pending), 32'd1);
        go_to(7);
        check("d3_pending7", 32'(d3_pending), 32'd1);
        go_to(8);
        check("d3_fail8",    32'(d3_fail),    32'd1);
        check("d3_pending8", 32'(d3_pending), 32'd0);
        go_to(9);
        check("d3_fail9",  32'(d3_fail),  32'd0);
        check("d3_count9", 32'(d3_count), 32'd1);

        // ---- DELAY=1, CNT_W=2: saturation, then clear ----
        do_reset();
        go_to(1);  antecedent = 1'b1;
        go_to(5);
        check("sat_count5", 32'(d1_count), 32'd3);
        go_to(9);  antecedent = 1'b0;
        go_to(10);
        check("sat_fail10",   32'(d1_fail),   32'd1);
        check("sat_count10",  32'(d1_count),  32'd3);
        check("sat_ts10",     32'(d1_ts),     32'd2);
        check("sat_sticky10", 32'(d1_sticky), 32'd1);
        go_to(11); clear = 1'b1; antecedent = 1'b1;
        check("sat_fail11",  32'(d1_fail),  32'd0);
        check("sat_count11", 32'(d1_count), 32'd3);
        go_to(12); clear = 1'b0; antecedent = 1'b0;
        check("clr_fail12",    32'(d1_fail),    32'd0);
        check("clr_sticky12",  32'(d1_sticky),  32'd0);
        check("clr_count12",   32'(d1_count),   32'd0);
        check("clr_ts12",      32'(d1_ts),      32'd0);
        check("clr_pending12", 32'(d1_pending), 32'd0);
        go_to(13); antecedent = 1'b1;
        check("clr_trig_pend13", 32'(d1_pending), 32'd0);
        go_to(14); antecedent = 1'b0; clear = 1'b1; consequent = 1'b0;
        check("clr_viol_pend14", 32'(d1_pending), 32'd1);
        go_to(15); clear = 1'b0;
        check("clr_viol_fail15",   32'(d1_fail),   32'd0);
        check("clr_viol_count15",  32'(d1_count),  32'd0);
        check("clr_viol_sticky15", 32'(d1_sticky), 32'd0);
        go_to(16); antecedent = 1'b1;
        go_to(17); antecedent = 1'b0;
        go_to(18);
        check("post_clr_fail18",  32'(d1_fail),  32'd1);
        check("post_clr_ts18",    32'(d1_ts),    32'd2);
        check("post_clr_count18", 32'(d1_count), 32'd1);

        // ---- DELAY=4, RESET mid-obligation ----
        do_reset();
        go_to(20); antecedent = 1'b1;
        go_to(21); antecedent = 1'b0;
        check("d4_pending21", 32'(d4_pending), 32'd1);
        go_to(22); RESET = 1'b1;
        check("d4_pending22", 32'(d4_pending), 32'd1);
        go_to(23); RESET = 1'b0;
        check("d4_pending23", 32'(d4_pending), 32'd0);
        check("d4_fail23",    32'(d4_fail),    32'd0);
        go_to(24);
        check("d4_fail24",    32'(d4_fail),    32'd0);
        check("d4_pending24", 32'(d4_pending), 32'd0);
        go_to(25);
        check("d4_fail25",   32'(d4_fail),   32'd0);
        check("d4_count25",  32'(d4_count),  32'd0);
        check("d4_sticky25", 32'(d4_sticky), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_implication_monitor

// File: doc/implication_monitor.md
# implication_monitor

Synthesizable run-time checker for a single-clock implication property `antecedent |-> ##DELAY consequent`. It sits directly downstream of a registered stage, such as a D flip-flop whose input is the antecedent and whose output is the consequent. It consumes the same pair of signals that a simulation-only inline assertion would watch, and turns violations into registered status usable on silicon or in emulation. Overlapping obligations are tracked independently. Failures are flagged, counted and timestamped.

## Interface
- `DELAY`, 1: cycles between antecedent and the consequent check; legal range 1..16.
- `CNT_W`, 8: width of the failure counter.
- `TS_W`, 16: width of the free-running cycle counter and the first-failure timestamp.

- `CLK`  in  1  sole clock, rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `enable`  in  1  qualifies new obligations only.
- `antecedent`  in  1  property trigger.
- `consequent`  in  1  value checked DELAY cycles after a qualified trigger.
- `clear`  in  1  synchronous soft clear of all monitor state.
- `fail`  out  1  one-cycle pulse per violated obligation.
- `fail_sticky`  out  1  high from the first violation until RESET/clear.
- `fail_count`  out  CNT_W  saturating count of violations.
- `first_fail_ts`  out  TS_W  cycle-counter value at the check cycle of the first violation.
- `pending`  out  1  at least one obligation outstanding.

## Operation
- Obligation pipe: `pipe[DELAY-1:0]`, a shift register.
  - Each cycle, `pipe[0] <= enable & antecedent` and `pipe[i] <= pipe[i-1]`.
  - Check cycle: the cycle in which `pipe[DELAY-1]` is 1. That cycle is exactly DELAY cycles after the trigger cycle.
- Violation: `pipe[DELAY-1] & ~consequent` in the check cycle.
- Deasserting `enable` blocks new triggers only. Obligations already in the pipe are still checked.
- Overlapping triggers, e.g. antecedent high on consecutive cycles, each produce an independent check.
- Cycle counter `ts`:
  - 0 after RESET or clear.
  - Increments every cycle and wraps modulo 2^TS_W.
- State machine, two states:
  - CLEAN: `fail_sticky` = 0. On a violation, go to FAILED and capture `first_fail_ts <= ts` at the check cycle.
  - FAILED: `fail_sticky` = 1. Later violations do not update `first_fail_ts`.
  - Leave FAILED only on RESET or clear.
- `fail_count` increments by 1 per violation and saturates at 2^CNT_W-1 without wrapping.
- `pending` = OR of all `pipe` bits. It is combinational from registers only.
- Priority: RESET > clear > normal operation.
  - clear zeroes `pipe`, `ts`, `fail_count`, `first_fail_ts` and the state.
  - A violation in the same cycle as clear is discarded.
  - A trigger in the same cycle as clear is discarded.

## Timing
- Reset values: `fail` 0, `fail_sticky` 0, `fail_count` 0, `first_fail_ts` 0, `pending` 0, state CLEAN.
- Trigger in cycle t, check in cycle t+DELAY.
- `fail` pulses in cycle t+DELAY+1, i.e. registered, one cycle after the check.
- `fail_sticky`, `fail_count` and `first_fail_ts` update in the same cycle as the `fail` pulse.
- RESET asserted mid-obligation drops all outstanding obligations. There is no `fail` in the cycle after RESET deasserts.
- `pending` rises the cycle after a qualified trigger. It falls the cycle after the last check.

## Configuration
- `IMPL_MONITOR_SVA_EN` defined:
  - Additionally emits the concurrent assertion `assert property (@(posedge CLK) disable iff (RESET || clear) enable && antecedent |-> ##DELAY consequent)`.
  - Also emits an elaboration-time check that DELAY is in 1..16.
  - Both are simulation only. The RTL outputs are unchanged.
- Undefined: no assertion constructs are emitted, and the block is pure synthesizable RTL.

## Structure
- Shared package `impl_monitor_pkg`:
  - state enum `mon_state_e` {CLEAN, FAILED};
  - constants `DELAY_MAX = 16` and `DELAY_MIN = 1`.
- One sub-module, `obligation_pipe`, parameterized by DELAY.
  - It holds the shift register and exposes `due` (= MSB) and `pending`.
- Counters, state and output registers stay in `implication_monitor`.

## Test plan
- DELAY=1, antecedent=1 at cycle 5, consequent=1 at cycle 6 -> `fail` never pulses, `pending` high in cycle 6 only, `fail_count`=0.
- DELAY=1, antecedent=1 at cycle 5, consequent=0 at cycle 6 -> `fail` pulse in cycle 7, `fail_sticky`=1, `fail_count`=1, `first_fail_ts`=6.
- DELAY=2:
  - Stimulus: antecedent high in cycles 10–12; consequent 0 in cycles 12 and 14, 1 in cycle 13.
  - Response: `fail` pulses in cycles 13 and 15, `fail_count`=2, `first_fail_ts`=12.
- DELAY=3, trigger at cycle 4, `enable` dropped in cycle 5, consequent=0 at cycle 7 -> `fail` pulse in cycle 8 (the in-flight obligation is still checked).
- CNT_W=2, eight violations -> `fail_count` stays at 3 after the third violation. Then clear -> all outputs 0 the next cycle, state CLEAN.
- Trigger at cycle 20 with DELAY=4, RESET in cycle 22, consequent=0 at cycle 24 -> no `fail`, `pending` 0 from cycle 23.
